// File: rtl/serial_adder_ctrl_pkg.sv
// serial_add_pkg: state codes and default width shared by the serial adder slice
package serial_add_pkg;
  localparam int N_DEFAULT = 8;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
endpackage

// File: rtl/serial_adder_ctrl_if.sv
// serial_adder_ctrl_if: operand/result handshake bundle for the serial adder
interface serial_adder_ctrl_if #(parameter int N = 8);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] x;
  logic [N-1:0] y;
  logic         c_in;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] s;
  logic         c_out;
  logic         busy;
  modport master (output in_valid, x, y, c_in, out_ready,
                  input  in_ready, out_valid, s, c_out, busy);
  modport slave  (input  in_valid, x, y, c_in, out_ready,
                  output in_ready, out_valid, s, c_out, busy);
endinterface

// File: rtl/serial_adder_ctrl_full_adder.sv
// full_adder: one-bit combinational full adder cell
module full_adder (
  input  logic x,
  input  logic y,
  input  logic c_in,
  output logic s,
  output logic c_out
);
  assign s     = x ^ y ^ c_in;
  assign c_out = (x & y) | (c_in & (x ^ y));
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial N-bit adder, one full_adder step per clock, LSB first
module serial_adder_ctrl
  import serial_add_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input logic clock,
  input logic reset,
  serial_adder_ctrl_if.slave bus
);
  localparam int CW = $clog2(N);
  logic [1:0]    state;
  logic [N-1:0]  xa, yb, acc;
  logic          carry;
  logic [CW-1:0] cnt;
  logic          fa_s, fa_c;
  full_adder fa (.x(xa[0]), .y(yb[0]), .c_in(carry), .s(fa_s), .c_out(fa_c));
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      xa    <= '0;
      yb    <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (state == S_IDLE) begin
      if (bus.in_valid) begin
        xa    <= bus.x;
        yb    <= bus.y;
        carry <= bus.c_in;
        cnt   <= '0;
        state <= S_RUN;
      end
    end else if (state == S_RUN) begin
      xa    <= xa >> 1;
      yb    <= yb >> 1;
      acc   <= {fa_s, acc[N-1:1]};
      carry <= fa_c;
      cnt   <= cnt + CW'(1);
      if (cnt == CW'(N - 1)) state <= S_DONE;
    end else if (state == S_DONE) begin
      if (bus.out_ready) state <= S_IDLE;
    end else begin
      state <= S_IDLE;
    end
  end
  assign bus.in_ready  = state == S_IDLE;
  assign bus.out_valid = state == S_DONE;
  assign bus.busy      = state == S_RUN;
  assign bus.s         = acc;
  assign bus.c_out     = carry;
endmodule
